// File: rtl/xadc_drp_responder.sv
// XADC stand-in for aux channel 15: timed conversion of sample_in with eoc, plus a DRP register port.
// Optional macro AVERAGE_EN: 4-sample averaging; result and eoc only on every 4th conversion.
module xadc_drp_responder #(
    parameter int unsigned CONV_CYCLES = 26,
    parameter int unsigned DRP_LATENCY = 2,
    parameter int unsigned EOC_WIDTH   = 4,
    parameter logic [15:0] TEMP_CODE   = 16'h9C40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        convst_in,
    input  logic [11:0] sample_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        eoc_out,
    output logic        busy_out,
    output logic [4:0]  channel_out
);
    localparam int unsigned CC_W = $clog2(CONV_CYCLES + 1);
    localparam int unsigned DL_W = $clog2(DRP_LATENCY + 1);
    localparam int unsigned EW_W = $clog2(EOC_WIDTH + 1);
    localparam logic [6:0]  A_TEMP = 7'h00;
    localparam logic [6:0]  A_RES  = 7'h1F;
    localparam logic [6:0]  A_STAT = 7'h3F;

    typedef enum logic {C_IDLE, C_CONV} conv_state_t;
    typedef enum logic {D_IDLE, D_WAIT} drp_state_t;

    conv_state_t     r_cstate, w_cstate_nx;
    drp_state_t      r_dstate, w_dstate_nx;
    logic            r_convst_d;
    logic [CC_W-1:0] r_ccnt, w_ccnt_nx;
    logic [11:0]     r_sample, w_sample_nx;
    logic [15:0]     r_result, w_result_nx;
    logic            r_busy, w_busy_nx;
    logic [4:0]      r_channel, w_channel_nx;
    logic [EW_W-1:0] r_eoc_cnt, w_eoc_cnt_nx;
    logic            r_eoc, w_eoc_nx;
    logic            r_overrun, w_overrun_nx;
    logic            r_proto_err, w_proto_err_nx;
    logic [DL_W-1:0] r_dcnt, w_dcnt_nx;
    logic [6:0]      r_addr, w_addr_nx;
    logic            r_we, w_we_nx;
    logic [1:0]      r_clr, w_clr_nx;
    logic [15:0]     r_do, w_do_nx;
    logic            r_drdy, w_drdy_nx;
    logic            w_edge, w_ovr_set, w_perr_set, w_complete;
    logic [1:0]      w_clr;
    logic [15:0]     w_rd_data;
    logic            w_unused_di;
`ifdef AVERAGE_EN
    logic [13:0]     r_acc, w_acc_nx;
    logic [1:0]      r_phase, w_phase_nx;
    logic [13:0]     w_acc_sum;

    assign w_acc_sum = r_acc + 14'(r_sample);
`endif

    assign w_edge      = convst_in & ~r_convst_d;
    assign w_unused_di = ^{di_in[15:3], di_in[0]};

    // Conversion FSM and eoc stretch
    always_comb begin
        w_cstate_nx  = r_cstate;
        w_ccnt_nx    = r_ccnt;
        w_sample_nx  = r_sample;
        w_result_nx  = r_result;
        w_busy_nx    = r_busy;
        w_channel_nx = r_channel;
        w_eoc_cnt_nx = r_eoc_cnt;
        w_ovr_set    = 1'b0;
`ifdef AVERAGE_EN
        w_acc_nx     = r_acc;
        w_phase_nx   = r_phase;
`endif
        if (r_eoc_cnt != EW_W'(0)) w_eoc_cnt_nx = r_eoc_cnt - EW_W'(1);
        case (r_cstate)
            C_IDLE: begin
                if (w_edge) begin
                    w_sample_nx = sample_in;
                    w_ccnt_nx   = CC_W'(CONV_CYCLES - 1);
                    w_busy_nx   = 1'b1;
                    w_cstate_nx = C_CONV;
                end
            end
            C_CONV: begin
                w_ovr_set = w_edge;
                if (r_ccnt == CC_W'(0)) begin
                    w_busy_nx    = 1'b0;
                    w_channel_nx = 5'h1F;
                    w_cstate_nx  = C_IDLE;
`ifdef AVERAGE_EN
                    w_phase_nx = r_phase + 2'd1;
                    if (r_phase == 2'd3) begin
                        w_result_nx  = {w_acc_sum[13:2], 4'b0000};
                        w_acc_nx     = 14'd0;
                        w_eoc_cnt_nx = EW_W'(EOC_WIDTH);
                    end else begin
                        w_acc_nx = w_acc_sum;
                    end
`else
                    w_result_nx  = {r_sample, 4'b0000};
                    w_eoc_cnt_nx = EW_W'(EOC_WIDTH);
`endif
                end else begin
                    w_ccnt_nx = r_ccnt - CC_W'(1);
                end
            end
            default: w_cstate_nx = C_IDLE;
        endcase
        w_eoc_nx = (w_eoc_cnt_nx != EW_W'(0));
    end

    // DRP FSM; read data uses register values from before this edge
    always_comb begin
        w_dstate_nx = r_dstate;
        w_dcnt_nx   = r_dcnt;
        w_addr_nx   = r_addr;
        w_we_nx     = r_we;
        w_clr_nx    = r_clr;
        w_do_nx     = r_do;
        w_drdy_nx   = 1'b0;
        w_perr_set  = 1'b0;
        w_complete  = 1'b0;
        w_clr       = 2'b00;
        w_rd_data   = 16'h0000;
        case (r_dstate)
            D_IDLE: begin
                if (den_in) begin
                    if (r_drdy) begin
                        w_perr_set = 1'b1;
                    end else begin
                        w_addr_nx = daddr_in;
                        w_we_nx   = dwe_in;
                        w_clr_nx  = di_in[2:1];
                        if (DRP_LATENCY == 1) begin
                            w_complete = 1'b1;
                        end else begin
                            w_dcnt_nx   = DL_W'(DRP_LATENCY - 2);
                            w_dstate_nx = D_WAIT;
                        end
                    end
                end
            end
            D_WAIT: begin
                w_perr_set = den_in;
                if (r_dcnt == DL_W'(0)) begin
                    w_complete  = 1'b1;
                    w_dstate_nx = D_IDLE;
                end else begin
                    w_dcnt_nx = r_dcnt - DL_W'(1);
                end
            end
            default: w_dstate_nx = D_IDLE;
        endcase
        case (w_addr_nx)
            A_TEMP:  w_rd_data = TEMP_CODE;
            A_RES:   w_rd_data = r_result;
            A_STAT:  w_rd_data = {13'd0, r_proto_err, r_overrun, r_busy};
            default: w_rd_data = 16'h0000;
        endcase
        if (w_complete) begin
            w_drdy_nx = 1'b1;
            w_do_nx   = w_we_nx ? 16'h0000 : w_rd_data;
            if (w_we_nx && (w_addr_nx == A_STAT)) w_clr = w_clr_nx;
        end
    end

    // Sticky status: a same-cycle set beats a write-clear
    assign w_overrun_nx   = w_ovr_set  | (r_overrun   & ~w_clr[0]);
    assign w_proto_err_nx = w_perr_set | (r_proto_err & ~w_clr[1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cstate    <= C_IDLE;
            r_dstate    <= D_IDLE;
            r_convst_d  <= 1'b0;
            r_ccnt      <= '0;
            r_sample    <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_channel   <= '0;
            r_eoc_cnt   <= '0;
            r_eoc       <= 1'b0;
            r_overrun   <= 1'b0;
            r_proto_err <= 1'b0;
            r_dcnt      <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_clr       <= '0;
            r_do        <= '0;
            r_drdy      <= 1'b0;
`ifdef AVERAGE_EN
            r_acc       <= '0;
            r_phase     <= '0;
`endif
        end else begin
            r_cstate    <= w_cstate_nx;
            r_dstate    <= w_dstate_nx;
            r_convst_d  <= convst_in;
            r_ccnt      <= w_ccnt_nx;
            r_sample    <= w_sample_nx;
            r_result    <= w_result_nx;
            r_busy      <= w_busy_nx;
            r_channel   <= w_channel_nx;
            r_eoc_cnt   <= w_eoc_cnt_nx;
            r_eoc       <= w_eoc_nx;
            r_overrun   <= w_overrun_nx;
            r_proto_err <= w_proto_err_nx;
            r_dcnt      <= w_dcnt_nx;
            r_addr      <= w_addr_nx;
            r_we        <= w_we_nx;
            r_clr       <= w_clr_nx;
            r_do        <= w_do_nx;
            r_drdy      <= w_drdy_nx;
`ifdef AVERAGE_EN
            r_acc       <= w_acc_nx;
            r_phase     <= w_phase_nx;
`endif
        end
    end

    assign do_out      = r_do;
    assign drdy_out    = r_drdy;
    assign eoc_out     = r_eoc;
    assign busy_out    = r_busy;
    assign channel_out = r_channel;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder: directed and randomized steps checked against a transaction-level model.
module tb_xadc_drp_responder;
    localparam int CONV_CYCLES = 26;
    localparam int DRP_LATENCY = 2;
    localparam int EOC_WIDTH   = 4;
    localparam logic [15:0] TEMP_CODE = 16'h9C40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        convst_in = 1'b0;
    logic [11:0] sample_in = '0;
    logic        den_in = 1'b0;
    logic        dwe_in = 1'b0;
    logic [6:0]  daddr_in = '0;
    logic [15:0] di_in = '0;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        eoc_out;
    logic        busy_out;
    logic [4:0]  channel_out;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_res;
    bit          m_ovr, m_perr;
    int          m_acc, m_n;

    xadc_drp_responder #(
        .CONV_CYCLES(CONV_CYCLES), .DRP_LATENCY(DRP_LATENCY),
        .EOC_WIDTH(EOC_WIDTH), .TEMP_CODE(TEMP_CODE)
    ) dut (
        .clk(clk), .reset(reset), .convst_in(convst_in), .sample_in(sample_in),
        .den_in(den_in), .dwe_in(dwe_in), .daddr_in(daddr_in), .di_in(di_in),
        .do_out(do_out), .drdy_out(drdy_out), .eoc_out(eoc_out),
        .busy_out(busy_out), .channel_out(channel_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [6:0] a);
        if (a == 7'h00) return TEMP_CODE;
        if (a == 7'h1F) return m_res;
        if (a == 7'h3F) return 16'(m_perr) * 16'd4 + 16'(m_ovr) * 16'd2;
        return 16'h0000;
    endfunction

    // Completion of one conversion; returns the expected eoc width
    task automatic model_complete(input logic [11:0] s, output int eoc_w);
`ifdef AVERAGE_EN
        m_acc = m_acc + int'(s);
        m_n   = m_n + 1;
        if (m_n == 4) begin
            m_res = 16'((m_acc / 4) * 16);
            m_acc = 0;
            m_n   = 0;
            eoc_w = EOC_WIDTH;
        end else begin
            eoc_w = 0;
        end
`else
        m_res = 16'(int'(s) * 16);
        eoc_w = EOC_WIDTH;
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; den_in = 1'b0; dwe_in = 1'b0; convst_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_res = '0; m_ovr = 0; m_perr = 0; m_acc = 0; m_n = 0;
    endtask

    task automatic drp(input logic [6:0] a, input bit we, input logic [15:0] d, input string tag);
        logic [15:0] exp;
        exp = we ? 16'h0000 : exp_read(a);
        @(posedge clk); #1;
        den_in = 1'b1; dwe_in = we; daddr_in = a; di_in = d;
        @(posedge clk); #1;
        den_in = 1'b0; dwe_in = 1'b0; daddr_in = 7'($urandom); di_in = 16'($urandom);
        for (int k = 1; k < DRP_LATENCY; k++) begin
            check({tag, "_early"}, 32'(drdy_out), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "_drdy"}, 32'(drdy_out), 32'd1);
        check({tag, "_data"}, 32'(do_out), 32'(exp));
        if (we && a == 7'h3F) begin
            if (d[1]) m_ovr = 0;
            if (d[2]) m_perr = 0;
        end
    endtask

    // One conversion; inject >= 0 raises a second convst that many cycles after the accepted edge
    task automatic convert(input logic [11:0] s, input string tag, input int inject);
        int n, m, ew;
        @(posedge clk); #1;
        sample_in = s; convst_in = 1'b1;
        @(posedge clk); #1;
        convst_in = 1'b0; sample_in = 12'($urandom);
        n = 0;
        while (busy_out === 1'b1 && n < 200) begin
            convst_in = (n == inject - 1);
            n++;
            @(posedge clk); #1;
        end
        convst_in = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(CONV_CYCLES));
        if (inject >= 0 && inject <= CONV_CYCLES) m_ovr = 1;
        model_complete(s, ew);
        m = 0;
        while (eoc_out === 1'b1 && m < 200) begin
            m++;
            @(posedge clk); #1;
        end
        check({tag, "_eoc_cycles"}, 32'(m), 32'(ew));
        check({tag, "_channel"}, 32'(channel_out), 32'h1F);
        check({tag, "_idle"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [15:0] prev;
        logic [11:0] s;
        logic [6:0]  a;
        int ew;

        do_reset();
        check("rst_do", 32'(do_out), 32'd0);
        check("rst_drdy", 32'(drdy_out), 32'd0);
        check("rst_eoc", 32'(eoc_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_channel", 32'(channel_out), 32'd0);
        drp(7'h1F, 0, 16'h0, "rd_res0");
        drp(7'h3F, 0, 16'h0, "rd_stat0");
        drp(7'h00, 0, 16'h0, "rd_temp");
        @(posedge clk); #1;
        check("hold_drdy", 32'(drdy_out), 32'd0);
        check("hold_do", 32'(do_out), 32'(TEMP_CODE));

        convert(12'hABC, "conv_abc", -1);
        drp(7'h1F, 0, 16'h0, "rd_abc");

        // Second edge 10 cycles in, then an edge on the completion cycle
        convert(12'h123, "conv_ovr", 10);
        bad = 0;
        repeat (10) begin
            if (eoc_out !== 1'b0 || busy_out !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("no_extra_eoc", 32'(bad), 32'd0);
        drp(7'h1F, 0, 16'h0, "rd_after_ovr");
        drp(7'h3F, 0, 16'h0, "rd_stat_ovr");
        drp(7'h3F, 1, 16'h0002, "wr_clr_ovr");
        drp(7'h3F, 0, 16'h0, "rd_stat_clr");
        convert(12'h456, "conv_last_edge", CONV_CYCLES);
        drp(7'h3F, 0, 16'h0, "rd_stat_ovr2");
        drp(7'h3F, 1, 16'hFFFF, "wr_clr_all");

        // den at t and t+1: one drdy at t+2, second den dropped
        @(posedge clk); #1;
        den_in = 1'b1; daddr_in = 7'h00;
        @(posedge clk); #1;
        daddr_in = 7'h1F;
        check("perr_t1_drdy", 32'(drdy_out), 32'd0);
        @(posedge clk); #1;
        den_in = 1'b0;
        check("perr_t2_drdy", 32'(drdy_out), 32'd1);
        check("perr_t2_data", 32'(do_out), 32'(TEMP_CODE));
        m_perr = 1;
        drp(7'h3F, 0, 16'h0, "perr_rd_t3");
        drp(7'h3F, 1, 16'h0004, "wr_clr_perr");

        // den in the drdy cycle is dropped
        den_in = 1'b1; daddr_in = 7'h00;
        @(posedge clk); #1;
        den_in = 1'b0;
        bad = 0;
        repeat (4) begin
            if (drdy_out !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("den_in_drdy_dropped", 32'(bad), 32'd0);
        m_perr = 1;
        drp(7'h3F, 0, 16'h0, "rd_stat_perr2");
        drp(7'h3F, 1, 16'h0004, "wr_clr_perr2");

        // Read drdy edge coincides with the result update
        prev = m_res;
        @(posedge clk); #1;
        sample_in = 12'h5A5; convst_in = 1'b1;
        @(posedge clk); #1;
        convst_in = 1'b0;
        repeat (CONV_CYCLES - DRP_LATENCY) @(posedge clk);
        #1;
        den_in = 1'b1; dwe_in = 1'b0; daddr_in = 7'h1F;
        @(posedge clk); #1;
        den_in = 1'b0;
        repeat (DRP_LATENCY - 1) @(posedge clk);
        #1;
        check("coinc_drdy", 32'(drdy_out), 32'd1);
        check("coinc_old_data", 32'(do_out), 32'(prev));
        check("coinc_busy_fell", 32'(busy_out), 32'd0);
        model_complete(12'h5A5, ew);
        repeat (EOC_WIDTH + 2) @(posedge clk);
        #1;
        drp(7'h1F, 0, 16'h0, "coinc_rd_new");

        // Reset mid-conversion and mid-DRP access
        @(posedge clk); #1;
        sample_in = 12'hFFF; convst_in = 1'b1; den_in = 1'b1; daddr_in = 7'h1F;
        @(posedge clk); #1;
        convst_in = 1'b0; den_in = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_res = '0; m_ovr = 0; m_perr = 0; m_acc = 0; m_n = 0;
        bad = 0;
        repeat (40) begin
            if (drdy_out !== 1'b0 || eoc_out !== 1'b0 || busy_out !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("rst_abort_quiet", 32'(bad), 32'd0);
        check("rst_abort_channel", 32'(channel_out), 32'd0);
        drp(7'h1F, 0, 16'h0, "rst_abort_rd");

        // Randomized conversions and register traffic
        for (int i = 0; i < 6; i++) begin
            s = 12'($urandom);
            convert(s, "rnd_conv", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, CONV_CYCLES)) : -1);
            case ($urandom_range(0, 3))
                0: a = 7'h00;
                1: a = 7'h1F;
                2: a = 7'h3F;
                default: a = 7'($urandom);
            endcase
            drp(a, 0, 16'h0, "rnd_rd");
            drp(7'($urandom_range(0, 62)), 1, 16'hFFFF, "rnd_wr_other");
            drp(7'h3F, 0, 16'h0, "rnd_stat");
            drp(7'h1F, 0, 16'h0, "rnd_res");
            if ($urandom_range(0, 1) == 1) drp(7'h3F, 1, 16'($urandom), "rnd_wr_stat");
        end

`ifdef AVERAGE_EN
        do_reset();
        convert(12'd100, "avg_100", -1);
        convert(12'd200, "avg_200", -1);
        convert(12'd300, "avg_300", -1);
        convert(12'd400, "avg_400", -1);
        drp(7'h1F, 0, 16'h0, "avg_rd");
        check("avg_value", 32'(do_out), 32'h0FA0);
        do_reset();
        convert(12'd100, "avg_pre_a", -1);
        convert(12'd200, "avg_pre_b", -1);
        do_reset();
        for (int i = 0; i < 4; i++) convert(12'd8, "avg_8", -1);
        drp(7'h1F, 0, 16'h0, "avg8_rd");
        check("avg8_value", 32'(do_out), 32'h0080);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
